pc_fetch_ctrl: RTL

//  Program-counter / fetch sequencer. Holds the PC, steps it sequentially and redirects it on

---
 rtl/pc_pkg.sv | 16 +
 rtl/sat_counter.sv | 34 +++
 rtl/pc_fetch_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and default parameters for the program-counter / fetch sequencer.
package pc_pkg;

    localparam int unsigned D_DEF        = 10;
    localparam int unsigned LUT_AW_DEF   = 4;
    localparam int unsigned CNT_W_DEF    = 16;
    localparam int unsigned START_PC_DEF = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter / fetch sequencer: sequential stepping, LUT-driven branch redirect,
// start/run/done sequencing with cycle and retired-instruction counters.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int unsigned D        = D_DEF,
    parameter int unsigned LUT_AW   = LUT_AW_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned START_PC = START_PC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              branch_en,
    input  logic [LUT_AW-1:0] branch_idx,
    input  logic              halt,
    output logic [LUT_AW-1:0] lut_addr,
    input  logic [D-1:0]      target,
    output logic [D-1:0]      prog_ctr,
    output logic              fetch_valid,
    output logic              done,
    output logic              pc_wrap,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instr_cnt
);

    localparam logic [D-1:0] START_PC_V = D'(START_PC);

    fetch_state_t state_q, state_d;
    logic [D-1:0] pc_q, pc_d;
    logic         wrap_q, wrap_d;
    logic         cnt_clr_c;
    logic         cyc_en_c;
    logic         ins_en_c;

    // State register together with PC and sticky wrap flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= START_PC_V;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wrap_q  <= wrap_d;
        end
    end

    // Next state / next PC; halt outranks branch, branch outranks sequential step.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        wrap_d    = wrap_q;
        cnt_clr_c = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    pc_d      = START_PC_V;
                    wrap_d    = 1'b0;
                    cnt_clr_c = 1'b1;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (halt) begin
                        state_d = DONE;
                    end else if (branch_en) begin
                        pc_d    = target;
                        state_d = FLUSH;
                    end else begin
                        pc_d = pc_q + D'(1);
                        if (pc_q == '1) begin
                            wrap_d = 1'b1;
                        end
                    end
                end
            end
            FLUSH: begin
                if (!stall) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        fetch_valid = (state_q == RUN);
        done        = (state_q == DONE);
        cyc_en_c    = (state_q == RUN) || (state_q == FLUSH);
        ins_en_c    = (state_q == RUN) && !stall;
    end

    assign lut_addr = branch_idx;
    assign prog_ctr = pc_q;
    assign pc_wrap  = wrap_q;

    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear_i (cnt_clr_c),
        .en_i    (cyc_en_c),
        .count_o (cycle_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_instr_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear_i (cnt_clr_c),
        .en_i    (ins_en_c),
        .count_o (instr_cnt)
    );

endmodule
